// File: rtl/fcp_crc_pkg.sv
// Shared types and the CRC-8 step function for the fcp_crc_stream block.
// The residue check is configured by the FCP_CRC_CHECK_EN macro in fcp_crc_stream.
package fcp_crc_pkg;

  // CRC-8 polynomial x^8+x^5+x^4+x^3+1 with the x^8 term implicit.
  localparam logic [7:0] FCP_CRC_POLY = 8'h39;
  localparam logic [7:0] FCP_CRC_INIT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fcp_state_e;

  // One byte folded MSB first, non-reflected, with no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                           input logic [7:0] b,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/fcp_crc_lanes.sv
// Combinational fold of every enabled byte lane of one beat into the CRC.
// Lanes are taken in ascending order; only the contiguous run of set keep
// bits starting at lane 0 counts, so a gap ends the beat.
module fcp_crc_lanes
  import fcp_crc_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter logic [7:0] POLY   = FCP_CRC_POLY,
  localparam int        NB     = DATA_W / 8,
  localparam int        CNT_W  = $clog2(NB) + 1
) (
  input  logic [7:0]        i_crc,
  input  logic [DATA_W-1:0] i_data,
  input  logic [NB-1:0]     i_keep,
  output logic [7:0]        o_crc,
  output logic [CNT_W-1:0]  o_cnt
);

  // Chain the byte steps and count lanes up to the first cleared keep bit.
  always_comb begin : fold
    logic run;
    o_crc = i_crc;
    o_cnt = '0;
    run   = 1'b1;
    for (int i = 0; i < NB; i++) begin
      run = run & i_keep[i];
      if (run) begin
        o_crc = crc8_byte(o_crc, i_data[8*i +: 8], POLY);
        o_cnt = o_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fcp_crc_stream.sv
// Streaming CRC-8 over framed byte beats with a held result handshake.
// Optional residue check: define FCP_CRC_CHECK_EN to drive crc_ok from the
// final CRC; otherwise crc_ok is tied low and no comparator is built.
module fcp_crc_stream
  import fcp_crc_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter logic [7:0] POLY   = FCP_CRC_POLY,
  parameter logic [7:0] INIT   = FCP_CRC_INIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [DATA_W/8-1:0]   s_keep,
  input  logic                  s_last,
  output logic                  crc_valid,
  input  logic                  crc_ready,
  output logic [7:0]            crc_out,
  output logic [15:0]           byte_cnt,
  output logic                  crc_ok
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(NB) + 1;

  fcp_state_e       r_state;
  fcp_state_e       w_state_nxt;
  logic [7:0]       r_crc;
  logic [15:0]      r_cnt;
  logic [7:0]       w_lane_crc;
  logic [CNT_W-1:0] w_lane_cnt;
  logic             w_accept;
  logic             w_release;

  // Byte count clamps at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [CNT_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign w_accept  = s_valid && s_ready;
  assign w_release = (r_state == ST_DONE) && crc_ready;

  fcp_crc_lanes #(
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_lanes (
    .i_crc  (r_crc),
    .i_data (s_data),
    .i_keep (s_keep),
    .o_crc  (w_lane_crc),
    .o_cnt  (w_lane_cnt)
  );

  // State register; rst outranks clr, which outranks every handshake.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_BUSY: if (w_accept) w_state_nxt = s_last ? ST_DONE : ST_BUSY;
        ST_DONE:          if (crc_ready) w_state_nxt = ST_IDLE;
        default:          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs follow the state directly.
  always_comb begin
    s_ready   = (r_state != ST_DONE);
    crc_valid = (r_state == ST_DONE);
  end

  // Running CRC and byte count; reloaded on abort or when the result is taken.
  always_ff @(posedge clk) begin
    if (rst || clr || w_release) begin
      r_crc <= INIT;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_crc <= w_lane_crc;
      r_cnt <= sat_add16(r_cnt, w_lane_cnt);
    end
  end

  assign crc_out  = r_crc;
  assign byte_cnt = r_cnt;

`ifdef FCP_CRC_CHECK_EN
  // A frame that ends with its own CRC byte leaves a zero residue.
  assign crc_ok = (r_state == ST_DONE) && (r_crc == 8'h00);
`else
  assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_fcp_crc_stream.sv
// Directed bench for fcp_crc_stream: one 8-bit and one 32-bit instance
// sharing clock, reset, clr, crc_ready and the low data/keep bits.
module tb_fcp_crc_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        crc_ready;
  logic        s_valid8;
  logic        s_valid32;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;

  logic        s_ready8, crc_valid8, crc_ok8;
  logic [7:0]  crc_out8;
  logic [15:0] byte_cnt8;
  logic        s_ready32, crc_valid32, crc_ok32;
  logic [7:0]  crc_out32;
  logic [15:0] byte_cnt32;

  int n_vec = 0;
  int n_err = 0;

`ifdef FCP_CRC_CHECK_EN
  localparam logic OK_EXP = 1'b1;
`else
  localparam logic OK_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  fcp_crc_stream #(.DATA_W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .s_valid   (s_valid8),
    .s_ready   (s_ready8),
    .s_data    (s_data[7:0]),
    .s_keep    (s_keep[0:0]),
    .s_last    (s_last),
    .crc_valid (crc_valid8),
    .crc_ready (crc_ready),
    .crc_out   (crc_out8),
    .byte_cnt  (byte_cnt8),
    .crc_ok    (crc_ok8)
  );

  fcp_crc_stream #(.DATA_W(32)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .s_valid   (s_valid32),
    .s_ready   (s_ready32),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .crc_valid (crc_valid32),
    .crc_ready (crc_ready),
    .crc_out   (crc_out32),
    .byte_cnt  (byte_cnt32),
    .crc_ok    (crc_ok32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Present one beat on the chosen instance for exactly one rising edge;
  // returns on the following falling edge with the beat removed.
  task automatic send(input bit to8, input logic [31:0] d, input logic [3:0] k, input logic l);
    @(negedge clk);
    s_valid8  = to8;
    s_valid32 = !to8;
    s_data    = d;
    s_keep    = k;
    s_last    = l;
    @(negedge clk);
    s_valid8  = 1'b0;
    s_valid32 = 1'b0;
    s_last    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; crc_ready = 1'b0;
    s_valid8 = 1'b0; s_valid32 = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, before any edge with rst low.
    chk("rst_s_ready32",  s_ready32,   1);
    chk("rst_valid32",    crc_valid32, 0);
    chk("rst_crc32",      crc_out32,   8'h00);
    chk("rst_cnt32",      byte_cnt32,  0);
    chk("rst_ok32",       crc_ok32,    0);
    chk("rst_s_ready8",   s_ready8,    1);

    // 8-bit: single byte 01 -> 39.
    send(1, 32'h01, 4'b0001, 1);
    chk("b8_01_valid",  crc_valid8, 1);
    chk("b8_01_crc",    crc_out8,   8'h39);
    chk("b8_01_cnt",    byte_cnt8,  1);
    chk("b8_01_ready",  s_ready8,   0);
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
    chk("b8_rel_valid", crc_valid8, 0);
    chk("b8_rel_ready", s_ready8,   1);
    chk("b8_rel_crc",   crc_out8,   8'h00);
    chk("b8_rel_cnt",   byte_cnt8,  0);

    // 8-bit: single byte 80 -> 4E.
    send(1, 32'h80, 4'b0001, 1);
    chk("b8_80_crc",    crc_out8,   8'h4E);
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;

    // 32-bit: bytes 01,39 in one beat leave zero residue.
    send(0, 32'h0000_3901, 4'b0011, 1);
    chk("res_valid", crc_valid32, 1);
    chk("res_crc",   crc_out32,   8'h00);
    chk("res_cnt",   byte_cnt32,  2);
    chk("res_ok",    crc_ok32,    OK_EXP);
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
    chk("res_rel_ok", crc_ok32, 0);

    // 32-bit: four lanes 01,02,03,04 -> 0E; result held while crc_ready low.
    send(0, 32'h0403_0201, 4'b1111, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", crc_valid32, 1);
      chk("hold_ready", s_ready32,   0);
      chk("hold_crc",   crc_out32,   8'h0E);
      chk("hold_cnt",   byte_cnt32,  4);
      chk("hold_ok",    crc_ok32,    0);
      @(negedge clk);
    end
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
    chk("hold_rel_valid", crc_valid32, 0);
    chk("hold_rel_ready", s_ready32,   1);

    // Multi-beat frame: lane 0 only, an empty beat, then a gapped keep.
    send(0, 32'hFFFF_FF01, 4'b0001, 0);
    chk("mb1_valid", crc_valid32, 0);
    chk("mb1_crc",   crc_out32,   8'h39);
    chk("mb1_cnt",   byte_cnt32,  1);
    chk("mb1_ready", s_ready32,   1);
    send(0, 32'hFFFF_FFFF, 4'b0000, 0);
    chk("mb2_crc",   crc_out32,   8'h39);
    chk("mb2_cnt",   byte_cnt32,  1);
    send(0, 32'hAAAA_AA39, 4'b1101, 1);
    chk("mb3_valid", crc_valid32, 1);
    chk("mb3_crc",   crc_out32,   8'h00);
    chk("mb3_cnt",   byte_cnt32,  2);
    chk("mb3_ok",    crc_ok32,    OK_EXP);
    crc_ready = 1'b1;
    @(negedge clk);

    // Back-to-back frames with crc_ready high: one DONE cycle between them.
    s_valid32 = 1'b1; s_data = 32'h01; s_keep = 4'b0001; s_last = 1'b1;
    @(negedge clk);
    chk("b2b_a_valid", crc_valid32, 1);
    chk("b2b_a_crc",   crc_out32,   8'h39);
    chk("b2b_a_ready", s_ready32,   0);
    s_data = 32'h80;
    @(negedge clk);
    chk("b2b_gap_valid", crc_valid32, 0);
    chk("b2b_gap_ready", s_ready32,   1);
    @(negedge clk);
    s_valid32 = 1'b0; s_last = 1'b0;
    chk("b2b_b_valid", crc_valid32, 1);
    chk("b2b_b_crc",   crc_out32,   8'h4E);
    @(negedge clk);
    chk("b2b_end_valid", crc_valid32, 0);
    crc_ready = 1'b0;

    // clr coinciding with an accepted last beat wins.
    @(negedge clk);
    s_valid8 = 1'b1; s_data = 32'h01; s_keep = 4'b0001; s_last = 1'b1; clr = 1'b1;
    @(negedge clk);
    s_valid8 = 1'b0; s_last = 1'b0; clr = 1'b0;
    chk("clr_valid", crc_valid8, 0);
    chk("clr_crc",   crc_out8,   8'h00);
    chk("clr_cnt",   byte_cnt8,  0);
    chk("clr_ready", s_ready8,   1);
    send(1, 32'h01, 4'b0001, 1);
    chk("clr_next_crc", crc_out8, 8'h39);
    // clr also drops a held result.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_done_valid", crc_valid8, 0);
    chk("clr_done_crc",   crc_out8,   8'h00);

    // rst mid-frame after three beats.
    send(0, 32'h01, 4'b0001, 0);
    send(0, 32'h02, 4'b0001, 0);
    send(0, 32'h03, 4'b0001, 0);
    chk("mid_cnt", byte_cnt32, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", crc_valid32, 0);
    chk("mid_rst_crc",   crc_out32,   8'h00);
    chk("mid_rst_cnt",   byte_cnt32,  0);
    chk("mid_rst_ready", s_ready32,   1);
    chk("mid_rst_ok",    crc_ok32,    0);
    send(0, 32'h01, 4'b0001, 1);
    chk("mid_next_crc",  crc_out32,   8'h39);
    chk("mid_next_cnt",  byte_cnt32,  1);
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;

    // Byte counter saturation: 16384 full beats reach 65536 bytes.
    s_valid32 = 1'b1; s_data = 32'h1234_5678; s_keep = 4'b1111; s_last = 1'b0;
    repeat (16383) @(negedge clk);
    chk("sat_below", byte_cnt32, 16'hFFFC);
    @(negedge clk);
    chk("sat_clamp", byte_cnt32, 16'hFFFF);
    s_last = 1'b1;
    @(negedge clk);
    s_valid32 = 1'b0; s_last = 1'b0;
    chk("sat_done_valid", crc_valid32, 1);
    chk("sat_done_cnt",   byte_cnt32,  16'hFFFF);
    crc_ready = 1'b1;
    @(negedge clk);
    chk("sat_rel_cnt", byte_cnt32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
